// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: issues in-order memory requests, buffers returned words in a
// small queue and flushes on redirects. Define FETCH_BYPASS_EN to present a response
// combinationally when the queue is empty.
module fetch_queue_stage #(
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_VECTOR    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_start,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_data_valid,
  output logic        if_valid,
  output logic [31:0] if_reg_pc,
  output logic [31:0] if_inst,
  output logic [63:0] if_inst_id,
  input  logic        if_stall_flg,
  input  logic        branch_hazard,
  input  logic [31:0] branch_target
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + OW;

  logic [31:0] q_pc   [QUEUE_DEPTH];
  logic [31:0] q_inst [QUEUE_DEPTH];
  logic [63:0] q_id   [QUEUE_DEPTH];
  logic [QW-1:0] q_head;
  logic [QW-1:0] q_tail;
  logic [CW-1:0] q_count;

  logic [31:0] pf_pc [MAX_OUTSTANDING];
  logic [PW-1:0] pf_rd;
  logic [PW-1:0] pf_wr;

  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [31:0]   fetch_pc;
  logic [63:0]   id_ctr;

  logic          q_empty;
  logic          resp_accept;
  logic          resp_keep;
  logic [31:0]   resp_pc;
  logic          bypass_hit;
  logic          out_lt_max;
  logic [SW-1:0] used_slots;
  logic          room_ok;
  logic          issue;
  logic          enq;
  logic          deq_q;

  function automatic logic [PW-1:0] pf_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign q_empty     = (q_count == '0);
  assign resp_accept = mem_data_valid && (outstanding != '0);
  assign resp_keep   = resp_accept && (discard == '0) && !branch_hazard;
  assign resp_pc     = pf_pc[pf_rd];

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = resp_keep && q_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // Outstanding requests reserve queue slots so a returning word always has room.
  assign out_lt_max = (outstanding < OW'(MAX_OUTSTANDING));
  assign used_slots = SW'(q_count) + SW'(outstanding);
  assign room_ok    = (used_slots < SW'(QUEUE_DEPTH));

  assign mem_start = rst_n && out_lt_max && (branch_hazard || room_ok);
  assign mem_addr  = (rst_n && branch_hazard) ? branch_target : fetch_pc;
  assign issue     = mem_start && mem_ready;

  assign if_valid = rst_n && !branch_hazard && (!q_empty || bypass_hit);
  assign enq      = resp_keep && !(bypass_hit && !if_stall_flg);
  assign deq_q    = if_valid && !if_stall_flg && !q_empty;

  always_comb begin
    if_reg_pc  = '0;
    if_inst    = '0;
    if_inst_id = '0;
    if (if_valid) begin
      if (q_empty) begin
        if_reg_pc  = resp_pc;
        if_inst    = mem_data;
        if_inst_id = id_ctr;
      end else begin
        if_reg_pc  = q_pc[q_head];
        if_inst    = q_inst[q_head];
        if_inst_id = q_id[q_head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[q_tail]   <= resp_pc;
      q_inst[q_tail] <= mem_data;
      q_id[q_tail]   <= id_ctr;
    end
    if (issue) begin
      pf_pc[pf_wr] <= mem_addr;
    end
  end

  // A redirect drops the queue contents; responses still owed to memory are counted
  // into discard so they are thrown away when they arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      pf_rd       <= '0;
      pf_wr       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= RESET_VECTOR;
      id_ctr      <= '0;
    end else begin
      if (branch_hazard) begin
        q_head  <= '0;
        q_tail  <= '0;
        q_count <= '0;
      end else begin
        if (enq) begin
          q_tail <= q_tail + QW'(1);
        end
        if (deq_q) begin
          q_head <= q_head + QW'(1);
        end
        case ({enq, deq_q})
          2'b10:   q_count <= q_count + CW'(1);
          2'b01:   q_count <= q_count - CW'(1);
          default: q_count <= q_count;
        endcase
      end

      case ({issue, resp_accept})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (branch_hazard) begin
        discard <= resp_accept ? outstanding - OW'(1) : outstanding;
      end else if (resp_accept && (discard != '0)) begin
        discard <= discard - OW'(1);
      end

      if (issue) begin
        fetch_pc <= mem_addr + 32'd4;
        pf_wr    <= pf_next(pf_wr);
      end else if (branch_hazard) begin
        fetch_pc <= branch_target;
      end

      if (resp_accept) begin
        pf_rd <= pf_next(pf_rd);
      end

      if (branch_hazard || resp_keep) begin
        id_ctr <= id_ctr + 64'd1;
      end
    end
  end

endmodule
